// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, icache request, one-entry fetch buffer.
// Hands instructions to decode and redirects on decode's pc_src choice.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] npc,
    input  logic        advance,
    input  logic [1:0]  pc_src,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] icount
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] icount_q, icount_d;
    logic [31:0] br_off;
    logic [31:0] pc_next;
    logic        take;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:   if (ihit) state_d = HOLD;
            HOLD:    if (advance) state_d = halt ? HALTED : FETCH;
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imemREN     = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            FETCH:   imemREN = 1'b1;
            HOLD:    instr_valid = 1'b1;
            HALTED:  halted = 1'b1;
            default: imemREN = 1'b0;
        endcase
    end

    assign take   = (state_q == HOLD) && advance;
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        pc_next = npc_q;
        unique case (pc_src)
            2'd0: pc_next = npc_q;
            2'd1: pc_next = npc_q + br_off;
            2'd2: pc_next = {npc_q[31:28], instr_q[25:0], 2'b00};
            2'd3: pc_next = {jr_addr[31:2], 2'b00};
            default: pc_next = npc_q;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        npc_d    = npc_q;
        icount_d = icount_q;
        if ((state_q == FETCH) && ihit) begin
            instr_d = iload;
            npc_d   = pc_q + 32'd4;
        end
        if (take) begin
            icount_d = icount_q + 32'd1;
            // a halting instruction leaves pc where it is
            if (!halt) pc_d = pc_next;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q     <= PC_INIT;
            instr_q  <= 32'h0;
            npc_q    <= 32'h0;
            icount_q <= 32'h0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            npc_q    <= npc_d;
            icount_q <= icount_d;
        end
    end

    assign imemaddr = pc_q;
    assign instr    = instr_q;
    assign npc      = npc_q;
    assign icount   = icount_q;

endmodule
